// File: rtl/ami_pkg.sv
// ami_pkg: constants and helpers shared by the AMI blocks.
//   - AXI burst, size and response encodings
//   - ami_pw(): width of a port-index field for a given port count
package ami_pkg;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [2:0] AXI_SIZE_1B   = 3'd0;
    localparam logic [2:0] AXI_SIZE_2B   = 3'd1;
    localparam logic [2:0] AXI_SIZE_4B   = 3'd2;
    localparam logic [2:0] AXI_SIZE_8B   = 3'd3;
    localparam logic [2:0] AXI_SIZE_16B  = 3'd4;
    localparam logic [2:0] AXI_SIZE_32B  = 3'd5;
    localparam logic [2:0] AXI_SIZE_64B  = 3'd6;
    localparam logic [2:0] AXI_SIZE_128B = 3'd7;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Port-index field width; never below 1 so a degenerate count still
    // yields a legal vector.
    function automatic int ami_pw(input int np);
        return (np > 1) ? $clog2(np) : 1;
    endfunction

endpackage

// File: rtl/ami_wmux_if.sv
// ami_wmux_if: AXI write-channel bundle (AW, W, B).
//   master modport: drives AW/W payload+valid and BREADY
//   slave  modport: drives AWREADY, WREADY and the B response
interface ami_wmux_if #(
    parameter int AXI_DW = 128,
    parameter int AXI_AW = 32,
    parameter int AXI_IW = 8,
    parameter int AXI_LW = 8
);
    localparam int AXI_WSTRBW = AXI_DW / 8;

    logic [AXI_IW-1:0]     AWID;
    logic [AXI_AW-1:0]     AWADDR;
    logic [AXI_LW-1:0]     AWLEN;
    logic [2:0]            AWSIZE;
    logic [1:0]            AWBURST;
    logic                  AWVALID;
    logic                  AWREADY;

    logic [AXI_DW-1:0]     WDATA;
    logic [AXI_WSTRBW-1:0] WSTRB;
    logic                  WLAST;
    logic                  WVALID;
    logic                  WREADY;

    logic [AXI_IW-1:0]     BID;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY
    );
endinterface

// File: rtl/sfifo.sv
// sfifo: small synchronous show-ahead FIFO.
//   ACLK/ARESETn : clock, asynchronous active-low reset
//   push/din     : write side (ignored when full)
//   pop/dout     : read side, dout shows the head entry (ignored when empty)
//   full/empty   : status
module sfifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          ACLK,
    input  logic          ARESETn,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);
    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push)
                wr_ptr_q <= (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            if (do_pop)
                rd_ptr_q <= (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            if (do_push && !do_pop)
                cnt_q <= cnt_q + 1'b1;
            else if (!do_push && do_pop)
                cnt_q <= cnt_q - 1'b1;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge ACLK) begin
        if (do_push)
            mem_q[wr_ptr_q] <= din;
    end
endmodule

// File: rtl/ami_wmux.sv
// ami_wmux: NP user write ports multiplexed onto one AXI write master.
//   ACLK, ARESETn : clock, asynchronous active-low reset
//   m_axi         : AXI AW/W/B master side (ami_wmux_if.master)
//   usr_aw*       : per-port AW request, usr_awready pulses on acceptance
//   usr_w*        : per-port W data, usr_wready only for the port owning
//                   the oldest issued burst
//   usr_b*        : B response routed by the port field in BID's top bits
//   err_wlast     : sticky per-port flag, user WLAST disagreed with ours
module ami_wmux
    import ami_pkg::*;
#(
    parameter int NP     = 4,
    parameter int AXI_DW = 128,
    parameter int AXI_AW = 32,
    parameter int AXI_IW = 8,
    parameter int AXI_LW = 8,
    parameter int AMI_OD = 4,
    localparam int PW    = ami_pw(NP),
    localparam int UW    = AXI_IW - PW,
    localparam int SW    = AXI_DW / 8
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    ami_wmux_if.master                 m_axi,
    input  logic [NP-1:0][UW-1:0]      usr_awid,
    input  logic [NP-1:0][AXI_AW-1:0]  usr_awaddr,
    input  logic [NP-1:0][AXI_LW-1:0]  usr_awlen,
    input  logic [NP-1:0][2:0]         usr_awsize,
    input  logic [NP-1:0][1:0]         usr_awburst,
    input  logic [NP-1:0]              usr_awvalid,
    output logic [NP-1:0]              usr_awready,
    input  logic [NP-1:0][AXI_DW-1:0]  usr_wdata,
    input  logic [NP-1:0][SW-1:0]      usr_wstrb,
    input  logic [NP-1:0]              usr_wlast,
    input  logic [NP-1:0]              usr_wvalid,
    output logic [NP-1:0]              usr_wready,
    output logic [UW-1:0]              usr_bid,
    output logic [1:0]                 usr_bresp,
    output logic [NP-1:0]              usr_bvalid,
    input  logic [NP-1:0]              usr_bready,
    output logic [NP-1:0]              err_wlast
);
    localparam int OW = $clog2(AMI_OD + 1);
    localparam int FW = PW + AXI_LW;

    // AW register and bookkeeping
    logic [AXI_IW-1:0] awid_q;
    logic [AXI_AW-1:0] awaddr_q;
    logic [AXI_LW-1:0] awlen_q;
    logic [2:0]        awsize_q;
    logic [1:0]        awburst_q;
    logic              awvalid_q;
    logic [PW-1:0]     rr_ptr_q;
    logic [OW-1:0]     ost_cc_q, ost_cc_d;
    logic [AXI_LW-1:0] beat_cc_q;
    logic [NP-1:0]     err_q, err_d;

    logic [PW-1:0]     arb_idx, grant;
    logic              grant_vld, aw_load, aw_hs, w_hs, b_hs;
    logic              fifo_full, fifo_empty, w_valid, w_last;
    logic [FW-1:0]     head;
    logic [PW-1:0]     head_port, b_port;
    logic [AXI_LW-1:0] head_len;

    // Round-robin search starting at rr_ptr_q.
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        arb_idx   = '0;
        for (int k = 0; k < NP; k++) begin
            arb_idx = PW'((int'(rr_ptr_q) + k) % NP);
            if (!grant_vld && usr_awvalid[arb_idx]) begin
                grant_vld = 1'b1;
                grant     = arb_idx;
            end
        end
    end

    // Gated by ARESETn so no ready pulse escapes while reset is held.
    assign aw_load = ARESETn && grant_vld && (!awvalid_q || m_axi.AWREADY)
                     && (ost_cc_q < OW'(AMI_OD));
    assign aw_hs   = awvalid_q && m_axi.AWREADY;
    assign b_port  = m_axi.BID[AXI_IW-1 -: PW];
    assign m_axi.BREADY = usr_bready[b_port];
    assign b_hs    = m_axi.BVALID && m_axi.BREADY;

    always_comb begin
        ost_cc_d = ost_cc_q;
        if (aw_load && !b_hs)
            ost_cc_d = ost_cc_q + 1'b1;
        else if (!aw_load && b_hs && ost_cc_q != '0)
            ost_cc_d = ost_cc_q - 1'b1;
    end

    // Order FIFO: which port owns the W beats next, and how many.
    sfifo #(.DW(FW), .DEPTH(AMI_OD)) u_order (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .push    (aw_hs && !fifo_full),
        .din     ({awid_q[AXI_IW-1 -: PW], awlen_q}),
        .pop     (w_hs && w_last),
        .dout    (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign head_port = head[FW-1 -: PW];
    assign head_len  = head[AXI_LW-1:0];
    assign w_valid   = !fifo_empty && usr_wvalid[head_port];
    assign w_last    = !fifo_empty && (beat_cc_q == head_len);
    assign w_hs      = w_valid && m_axi.WREADY;

    always_comb begin
        err_d = err_q;
        if (w_hs && (usr_wlast[head_port] != w_last))
            err_d[head_port] = 1'b1;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            awid_q    <= '0;
            awaddr_q  <= '0;
            awlen_q   <= '0;
            awsize_q  <= '0;
            awburst_q <= '0;
            awvalid_q <= 1'b0;
            rr_ptr_q  <= '0;
            ost_cc_q  <= '0;
            beat_cc_q <= '0;
            err_q     <= '0;
        end else begin
            if (aw_load) begin
                awid_q    <= {grant, usr_awid[grant]};
                awaddr_q  <= usr_awaddr[grant];
                awlen_q   <= usr_awlen[grant];
                awsize_q  <= usr_awsize[grant];
                awburst_q <= usr_awburst[grant];
                awvalid_q <= 1'b1;
                rr_ptr_q  <= (grant == PW'(NP - 1)) ? '0 : grant + 1'b1;
            end else if (aw_hs) begin
                awvalid_q <= 1'b0;
            end
            ost_cc_q <= ost_cc_d;
            if (w_hs)
                beat_cc_q <= w_last ? '0 : beat_cc_q + 1'b1;
            err_q <= err_d;
        end
    end

    assign m_axi.AWID    = awid_q;
    assign m_axi.AWADDR  = awaddr_q;
    assign m_axi.AWLEN   = awlen_q;
    assign m_axi.AWSIZE  = awsize_q;
    assign m_axi.AWBURST = awburst_q;
    assign m_axi.AWVALID = awvalid_q;
    assign m_axi.WDATA   = usr_wdata[head_port];
    assign m_axi.WSTRB   = usr_wstrb[head_port];
    assign m_axi.WLAST   = w_last;
    assign m_axi.WVALID  = w_valid;

    assign usr_bid   = m_axi.BID[UW-1:0];
    assign usr_bresp = m_axi.BRESP;
    assign err_wlast = err_q;

    for (genvar gi = 0; gi < NP; gi++) begin : g_port
        assign usr_awready[gi] = aw_load && (grant == PW'(gi));
        assign usr_wready[gi]  = !fifo_empty && (head_port == PW'(gi)) && m_axi.WREADY;
        assign usr_bvalid[gi]  = m_axi.BVALID && (b_port == PW'(gi));
    end
endmodule
